// File: rtl/ili9341_rect_fill_sequencer.sv
// Fill-rectangle -> ILI9341 byte stream (CASET/PASET/RAMWR + RGB565 pixels); first byte the cycle after accept, then one byte per handshake.
// Backpressure: tx_valid holds with tx_data/tx_dc stable until tx_ready; requests only accepted in IDLE.
module ili9341_rect_fill_sequencer #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int CW     = 9,
  parameter int NW     = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_x0,
  input  logic [CW-1:0] req_y0,
  input  logic [CW-1:0] req_x1,
  input  logic [CW-1:0] req_y1,
  input  logic [15:0]   req_color,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_dc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET, S_CASET_ARG, S_PASET, S_PASET_ARG, S_RAMWR, S_PIX_HI, S_PIX_LO
  } state_t;

  localparam logic [CW:0] X_LIM = (CW+1)'(WIDTH);
  localparam logic [CW:0] Y_LIM = (CW+1)'(HEIGHT);

  state_t        state;
  logic [1:0]    arg_idx;
  logic [NW-1:0] pix_cnt;
  logic [CW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [15:0]   color_q;

  logic          req_ok;
  logic [NW-1:0] span_x, span_y, area;

  assign req_ok = (req_x0 <= req_x1) && (req_y0 <= req_y1) &&
                  ({1'b0, req_x1} < X_LIM) && ({1'b0, req_y1} < Y_LIM);
  // Spans are widened before the multiply so a full-panel fill does not wrap.
  assign span_x = NW'(req_x1) - NW'(req_x0) + NW'(1);
  assign span_y = NW'(req_y1) - NW'(req_y0) + NW'(1);
  assign area   = span_x * span_y;

  function automatic logic [7:0] arg_byte(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                          input logic [1:0] idx);
    logic [15:0] a16;
    logic [15:0] b16;
    a16 = 16'(a);
    b16 = 16'(b);
    case (idx)
      2'd0:    arg_byte = a16[15:8];
      2'd1:    arg_byte = a16[7:0];
      2'd2:    arg_byte = b16[15:8];
      default: arg_byte = b16[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      tx_dc     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      arg_idx   <= 2'd0;
      pix_cnt   <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= 16'h0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            x0_q    <= req_x0;
            y0_q    <= req_y0;
            x1_q    <= req_x1;
            y1_q    <= req_y1;
            color_q <= req_color;
            if (req_ok) begin
              pix_cnt   <= area;
              arg_idx   <= 2'd0;
              state     <= S_CASET;
              tx_valid  <= 1'b1;
              tx_data   <= 8'h2A;
              tx_dc     <= 1'b0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              // Rejected: stay idle and report it without touching the bus.
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        S_CASET: begin
          if (tx_ready) begin
            state   <= S_CASET_ARG;
            arg_idx <= 2'd0;
            tx_data <= arg_byte(x0_q, x1_q, 2'd0);
            tx_dc   <= 1'b1;
          end
        end
        S_CASET_ARG: begin
          if (tx_ready) begin
            arg_idx <= arg_idx + 2'd1;
            if (arg_idx == 2'd3) begin
              state   <= S_PASET;
              tx_data <= 8'h2B;
              tx_dc   <= 1'b0;
            end else begin
              tx_data <= arg_byte(x0_q, x1_q, arg_idx + 2'd1);
            end
          end
        end
        S_PASET: begin
          if (tx_ready) begin
            state   <= S_PASET_ARG;
            arg_idx <= 2'd0;
            tx_data <= arg_byte(y0_q, y1_q, 2'd0);
            tx_dc   <= 1'b1;
          end
        end
        S_PASET_ARG: begin
          if (tx_ready) begin
            arg_idx <= arg_idx + 2'd1;
            if (arg_idx == 2'd3) begin
              state   <= S_RAMWR;
              tx_data <= 8'h2C;
              tx_dc   <= 1'b0;
            end else begin
              tx_data <= arg_byte(y0_q, y1_q, arg_idx + 2'd1);
            end
          end
        end
        S_RAMWR: begin
          if (tx_ready) begin
            state   <= S_PIX_HI;
            tx_data <= color_q[15:8];
            tx_dc   <= 1'b1;
          end
        end
        S_PIX_HI: begin
          if (tx_ready) begin
            state   <= S_PIX_LO;
            tx_data <= color_q[7:0];
          end
        end
        S_PIX_LO: begin
          if (tx_ready) begin
            pix_cnt <= pix_cnt - NW'(1);
            if (pix_cnt == NW'(1)) begin
              state     <= S_IDLE;
              tx_valid  <= 1'b0;
              tx_data   <= 8'h00;
              tx_dc     <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              done      <= 1'b1;
            end else begin
              state   <= S_PIX_HI;
              tx_data <= color_q[15:8];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ili9341_rect_fill_sequencer.sv
// Bench for ili9341_rect_fill_sequencer: expected byte streams come from a list-of-bytes model of the display protocol.
module tb_ili9341_rect_fill_sequencer;

  localparam int W  = 240;
  localparam int H  = 80;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_x0, req_y0, req_x1, req_y1;
  logic [15:0]   req_color;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_dc;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  ili9341_rect_fill_sequencer #(.WIDTH(W), .HEIGHT(H), .CW(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_y0    (req_y0),
    .req_x1    (req_x1),
    .req_y1    (req_y1),
    .req_color (req_color),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_dc     (tx_dc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected {dc,data} sequence for a rectangle, straight from the command set.
  task automatic build(input int x0, input int y0, input int x1, input int y1, input logic [15:0] col);
    int v[4];
    int pix;
    v = '{x0, x1, y0, y1};
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    for (int k = 0; k < 4; k++) begin
      if (k == 2) exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, 8'((v[k] >> 8) & 255)});
      exp_q.push_back({1'b1, 8'(v[k] & 255)});
    end
    exp_q.push_back({1'b0, 8'h2C});
    pix = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int p = 0; p < pix; p++) begin
      exp_q.push_back({1'b1, col[15:8]});
      exp_q.push_back({1'b1, col[7:0]});
    end
  endtask

  // Entered in the cycle after accept; returns in the done cycle.
  task automatic stream(input int pct, output int ncyc);
    int         budget;
    logic       stalled;
    logic       rdy;
    logic [8:0] held;
    logic [8:0] want;
    budget  = 4 * exp_q.size() + 100;
    stalled = 1'b0;
    held    = '0;
    ncyc    = 0;
    while (exp_q.size() > 0 && ncyc < budget) begin
      chk("tx_valid_held", 32'(tx_valid), 32'd1);
      chk("busy_streaming", 32'(busy), 32'd1);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("no_early_done", 32'(done), 32'd0);
      if (stalled) chk("stall_stable", 32'({tx_dc, tx_data}), 32'(held));
      rdy      = (int'($urandom_range(99)) < pct);
      tx_ready = rdy;
      if (rdy) begin
        want = exp_q.pop_front();
        chk("dc_data", 32'({tx_dc, tx_data}), 32'(want));
      end
      held    = {tx_dc, tx_data};
      stalled = !rdy;
      cyc();
      ncyc++;
    end
    chk("stream_timeout", 32'(exp_q.size()), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("err_clear", 32'(err), 32'd0);
    chk("tx_valid_end", 32'(tx_valid), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("req_ready_end", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input int x0, input int y0, input int x1, input int y1,
                        input logic [15:0] col, input int pct);
    logic ok;
    int   tot;
    int   n;
    ok = (x0 <= x1) && (y0 <= y1) && (x1 < W) && (y1 < H);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    if (ok) build(x0, y0, x1, y1, col);
    else exp_q.delete();
    tot       = exp_q.size();
    req_x0    = CW'(x0);
    req_y0    = CW'(y0);
    req_x1    = CW'(x1);
    req_y1    = CW'(y1);
    req_color = col;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    if (ok) begin
      stream(pct, n);
      if (pct >= 100) chk("stream_cycles", 32'(n), 32'(tot));
    end else begin
      chk("inv_tx_valid", 32'(tx_valid), 32'd0);
      chk("inv_done", 32'(done), 32'd1);
      chk("inv_err", 32'(err), 32'd1);
      chk("inv_req_ready", 32'(req_ready), 32'd1);
    end
    cyc();
    chk("done_single", 32'(done), 32'd0);
    chk("idle_tx_valid", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    int n;
    int x0, y0, x1, y1;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x0    = '0;
    req_y0    = '0;
    req_x1    = '0;
    req_y1    = '0;
    req_color = 16'h0000;
    tx_ready  = 1'b0;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_dc", 32'(tx_dc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cyc();

    do_req(0, 0, 0, 0, 16'hF800, 100);
    do_req(0, 0, W-1, H-1, 16'h001F, 100);
    do_req(10, 20, 12, 21, 16'hA5C3, 50);
    do_req(5, 0, 4, 0, 16'h1111, 100);
    do_req(0, 0, 240, 0, 16'h2222, 100);
    do_req(0, 0, 0, H, 16'h3333, 100);

    // Reset in the middle of the pixel bytes of a 10x10 fill.
    req_x0    = CW'(0);
    req_y0    = CW'(0);
    req_x1    = CW'(9);
    req_y1    = CW'(9);
    req_color = 16'hBEEF;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    tx_ready  = 1'b1;
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (3) begin
      cyc();
      chk("post_rst_no_done", 32'(done), 32'd0);
    end
    do_req(1, 1, 1, 1, 16'h1234, 100);

    // Back-to-back: the second request stays valid for the whole first stream.
    build(2, 3, 4, 3, 16'hCAFE);
    req_x0    = CW'(2);
    req_y0    = CW'(3);
    req_x1    = CW'(4);
    req_y1    = CW'(3);
    req_color = 16'hCAFE;
    req_valid = 1'b1;
    cyc();
    req_x0    = CW'(7);
    req_y0    = CW'(7);
    req_x1    = CW'(8);
    req_y1    = CW'(8);
    req_color = 16'h0F0F;
    stream(100, n);
    build(7, 7, 8, 8, 16'h0F0F);
    cyc();
    req_valid = 1'b0;
    stream(70, n);
    cyc();
    chk("b2b_done_single", 32'(done), 32'd0);

    repeat (25) begin
      x0 = int'($urandom_range(W-1));
      x1 = x0 + int'($urandom_range(3));
      y0 = int'($urandom_range(H-1));
      y1 = y0 + int'($urandom_range(3));
      if ($urandom_range(7) == 0) x0 = x1 + 1;
      do_req(x0, y0, x1, y1, 16'($urandom), int'($urandom_range(40, 100)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
